// File: rtl/alu_issue_ctrl_pkg.sv
// alu_issue_ctrl_pkg: shared opcode type, ALU geometry constants, command struct and ALU reference function
package alu_issue_ctrl_pkg;
   typedef enum logic [1:0] {ADD, SUB, NOT_A, REDUCTION_OR_B} opcode_e;
   localparam int ALU_IN_W = 4;
   localparam int ALU_OUT_W = 5;
   localparam int ALU_LAT = 2;
   localparam int TAG_W_DEF = 4;
   typedef struct packed {
      opcode_e opcode;
      logic signed [ALU_IN_W-1:0] a;
      logic signed [ALU_IN_W-1:0] b;
      logic [TAG_W_DEF-1:0] tag;
   } alu_cmd_t;
   function automatic logic signed [ALU_OUT_W-1:0] alu_model(opcode_e op, logic signed [ALU_IN_W-1:0] a, logic signed [ALU_IN_W-1:0] b);
      logic signed [ALU_OUT_W-1:0] sa, sb;
      sa = ALU_OUT_W'(a);
      sb = ALU_OUT_W'(b);
      return op == ADD ? sa + sb : op == SUB ? sa - sb : op == NOT_A ? ~sa : {{(ALU_OUT_W-1){1'b0}}, |b};
   endfunction
endpackage

// File: rtl/alu_issue_ctrl_if.sv
// alu_issue_ctrl_if: command, ALU and result channels of alu_issue_ctrl; slave = controller view, master = environment view
interface alu_issue_ctrl_if import alu_issue_ctrl_pkg::*; #(
   parameter int CMD_DEPTH = 4,
   parameter int TAG_W = 4
);
   logic cmd_valid, cmd_ready;
   opcode_e cmd_opcode;
   logic signed [ALU_IN_W-1:0] cmd_a, cmd_b;
   opcode_e alu_opcode;
   logic signed [ALU_IN_W-1:0] alu_a, alu_b;
   logic signed [ALU_OUT_W-1:0] alu_c;
   logic res_valid, res_ready;
   logic signed [ALU_OUT_W-1:0] res_data;
   opcode_e res_opcode;
   logic [TAG_W-1:0] res_tag;
   logic [$clog2(CMD_DEPTH):0] cmd_count;
   logic [7:0] mismatch_cnt;
   modport slave (
      input cmd_valid, cmd_opcode, cmd_a, cmd_b, alu_c, res_ready,
      output cmd_ready, alu_opcode, alu_a, alu_b, res_valid, res_data, res_opcode, res_tag, cmd_count, mismatch_cnt
   );
   modport master (
      output cmd_valid, cmd_opcode, cmd_a, cmd_b, alu_c, res_ready,
      input cmd_ready, alu_opcode, alu_a, alu_b, res_valid, res_data, res_opcode, res_tag, cmd_count, mismatch_cnt
   );
endinterface

// File: rtl/alu_cmd_fifo.sv
// alu_cmd_fifo: synchronous FIFO of T with occupancy count and full/empty; ports clk, reset, push/din, pop/dout, count, full, empty
module alu_cmd_fifo import alu_issue_ctrl_pkg::*; #(
   parameter int DEPTH = 4,
   parameter type T = alu_cmd_t
) (
   input logic clk,
   input logic reset,
   input logic push,
   input T din,
   input logic pop,
   output T dout,
   output logic [$clog2(DEPTH):0] count,
   output logic full,
   output logic empty
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   T mem [DEPTH];
   logic [AW-1:0] wp, rp;
   logic do_push, do_pop;
   assign full = count == CW'(DEPTH);
   assign empty = count == '0;
   assign do_push = push && !full;
   assign do_pop = pop && !empty;
   assign dout = mem[rp];
   always_ff @(posedge clk)
      if (do_push) mem[wp] <= din;
   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         wp <= '0;
         rp <= '0;
         count <= '0;
      end else begin
         if (do_push) wp <= wp + 1'b1;
         if (do_pop) rp <= rp + 1'b1;
         count <= count + CW'(do_push) - CW'(do_pop);
      end
endmodule

// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl: buffers commands, issues them to the registered ALU, returns tagged results in order
// Ports: clk, reset (async, active-high), bus (slave): cmd valid/ready channel, alu opcode/a/b out and c in,
// res valid/ready channel with data/opcode/tag, cmd_count, mismatch_cnt.
// Optional ALU_ISSUE_SELF_CHECK_EN: golden model counts ALU result mismatches; otherwise mismatch_cnt is 0.
module alu_issue_ctrl import alu_issue_ctrl_pkg::*; #(
   parameter int CMD_DEPTH = 4,
   parameter int RES_DEPTH = 2,
   parameter int TAG_W = 4
) (
   input logic clk,
   input logic reset,
   alu_issue_ctrl_if.slave bus
);
   localparam int CW = $clog2(CMD_DEPTH) + 1;
   localparam int RA = $clog2(RES_DEPTH);
   localparam int RW = $clog2(RES_DEPTH + 1);
   typedef struct packed {
      opcode_e opcode;
      logic signed [ALU_IN_W-1:0] a;
      logic signed [ALU_IN_W-1:0] b;
      logic [TAG_W-1:0] tag;
   } cmd_t;
   typedef struct packed {
      logic signed [ALU_OUT_W-1:0] data;
      opcode_e opcode;
      logic [TAG_W-1:0] tag;
   } res_t;
   cmd_t head;
   logic full, empty, push, issue, cap, pop;
   logic [CW-1:0] count;
   logic [TAG_W-1:0] tag_cnt;
   logic [ALU_LAT-1:0] pv;
   opcode_e p_op [ALU_LAT];
   logic [TAG_W-1:0] p_tag [ALU_LAT];
   res_t rbuf [RES_DEPTH];
   logic [RA-1:0] wp, rp;
   logic [RW-1:0] rc;
   assign push = bus.cmd_valid && !full;
   // every in-flight entry holds a reserved result slot, so a capture can never find the buffer full
   assign issue = !empty && (int'(rc) + $countones(pv) < RES_DEPTH);
   assign cap = pv[ALU_LAT-1];
   assign pop = rc != '0 && bus.res_ready;
   alu_cmd_fifo #(.DEPTH(CMD_DEPTH), .T(cmd_t)) u_fifo (
      .clk(clk),
      .reset(reset),
      .push(push),
      .din(cmd_t'{bus.cmd_opcode, bus.cmd_a, bus.cmd_b, tag_cnt}),
      .pop(issue),
      .dout(head),
      .count(count),
      .full(full),
      .empty(empty)
   );
   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         tag_cnt <= '0;
         pv <= '0;
         bus.alu_opcode <= ADD;
         bus.alu_a <= '0;
         bus.alu_b <= '0;
         for (int i = 0; i < ALU_LAT; i++) begin
            p_op[i] <= ADD;
            p_tag[i] <= '0;
         end
         for (int i = 0; i < RES_DEPTH; i++) rbuf[i] <= '0;
         wp <= '0;
         rp <= '0;
         rc <= '0;
      end else begin
         if (push) tag_cnt <= tag_cnt + 1'b1;
         pv <= {pv[ALU_LAT-2:0], issue};
         if (issue) begin
            bus.alu_opcode <= head.opcode;
            bus.alu_a <= head.a;
            bus.alu_b <= head.b;
            p_op[0] <= head.opcode;
            p_tag[0] <= head.tag;
         end
         for (int i = 1; i < ALU_LAT; i++) begin
            p_op[i] <= p_op[i-1];
            p_tag[i] <= p_tag[i-1];
         end
         if (cap) begin
            rbuf[wp] <= '{data: bus.alu_c, opcode: p_op[ALU_LAT-1], tag: p_tag[ALU_LAT-1]};
            wp <= wp == RA'(RES_DEPTH - 1) ? '0 : wp + 1'b1;
         end
         if (pop) rp <= rp == RA'(RES_DEPTH - 1) ? '0 : rp + 1'b1;
         rc <= rc + RW'(cap) - RW'(pop);
      end
   assign bus.cmd_ready = !full;
   assign bus.cmd_count = count;
   assign bus.res_valid = rc != '0;
   assign bus.res_data = rbuf[rp].data;
   assign bus.res_opcode = rbuf[rp].opcode;
   assign bus.res_tag = rbuf[rp].tag;
`ifdef ALU_ISSUE_SELF_CHECK_EN
   logic signed [ALU_IN_W-1:0] p_a [ALU_LAT];
   logic signed [ALU_IN_W-1:0] p_b [ALU_LAT];
   logic [7:0] mm;
   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         for (int i = 0; i < ALU_LAT; i++) begin
            p_a[i] <= '0;
            p_b[i] <= '0;
         end
         mm <= '0;
      end else begin
         if (issue) begin
            p_a[0] <= head.a;
            p_b[0] <= head.b;
         end
         for (int i = 1; i < ALU_LAT; i++) begin
            p_a[i] <= p_a[i-1];
            p_b[i] <= p_b[i-1];
         end
         if (cap && bus.alu_c != alu_model(p_op[ALU_LAT-1], p_a[ALU_LAT-1], p_b[ALU_LAT-1]) && mm != 8'hff) mm <= mm + 1'b1;
      end
   assign bus.mismatch_cnt = mm;
`else
   assign bus.mismatch_cnt = '0;
`endif
endmodule
